// File: rtl/mem_req_queue_pkg.sv
// Shared definitions for the EX->MEM memory request stage: memory op codes,
// kseg0/kseg1 mapping constants and small op-classification helpers.
package mem_req_queue_pkg;

   typedef enum logic [3:0] {
      EXE_NOP_OP = 4'd0,
      EXE_LB_OP  = 4'd1,
      EXE_LBU_OP = 4'd2,
      EXE_LH_OP  = 4'd3,
      EXE_LHU_OP = 4'd4,
      EXE_LW_OP  = 4'd5,
      EXE_LL_OP  = 4'd6,
      EXE_LWL_OP = 4'd7,
      EXE_LWR_OP = 4'd8,
      EXE_SB_OP  = 4'd9,
      EXE_SH_OP  = 4'd10,
      EXE_SW_OP  = 4'd11,
      EXE_SC_OP  = 4'd12,
      EXE_SWL_OP = 4'd13,
      EXE_SWR_OP = 4'd14
   } mem_op_e;

   // kseg0/kseg1 share the 2'b10 top bits; both map onto the low 512 MB
   localparam logic [1:0] KSEG01_SEL  = 2'b10;
   localparam int         KSEG_PHYS_W = 29;

   function automatic logic is_load(input logic [3:0] op);
      logic r;
      case (op)
         EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
         EXE_LW_OP, EXE_LL_OP, EXE_LWL_OP, EXE_LWR_OP: r = 1'b1;
         default:                                      r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      logic r;
      case (op)
         EXE_SB_OP, EXE_SH_OP, EXE_SW_OP,
         EXE_SC_OP, EXE_SWL_OP, EXE_SWR_OP: r = 1'b1;
         default:                           r = 1'b0;
      endcase
      return r;
   endfunction

   // Unaligned-word ops (LWL/LWR/SWL/SWR) and byte ops can never fault
   function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
      logic r;
      case (op)
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:          r = a[0];
         EXE_LW_OP, EXE_LL_OP, EXE_SW_OP, EXE_SC_OP: r = (a != 2'b00);
         default:                                    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_req_queue_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head entry is visible
// combinationally on rdata_o while not empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty_o = (wptr_q == rptr_q);
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   // Next pointer values; a push into a full FIFO or pop from an empty one is ignored
   always_comb begin
      do_push_s = push_i & ~full_o;
      do_pop_s  = pop_i & ~empty_o;
      wptr_d    = wptr_q + {{AW{1'b0}}, do_push_s};
      rptr_d    = rptr_q + {{AW{1'b0}}, do_pop_s};
   end

   // Pointer registers; reset empties the FIFO and discards any queued entries
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Entry storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/mem_req_queue.sv
// EX->MEM memory request stage: decodes load/store ops, builds byte enables
// and lane-aligned store data, checks alignment, maps kseg0/kseg1 addresses
// and queues requests toward the data bus.
module mem_req_queue
   import mem_req_queue_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 4,
   parameter int KSEG_MAP = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_valid_i,
   input  logic [3:0]          ex_op_i,
   input  logic [31:0]         ex_addr_i,
   input  logic [31:0]         ex_wdata_i,
   input  logic                ex_except_i,
   input  logic                llbit_i,
   input  logic                stall_i,
   input  logic                flush_i,
   output logic                req_valid_o,
   input  logic                req_ready_i,
   output logic                req_we_o,
   output logic [DATA_W/8-1:0] req_be_o,
   output logic [31:0]         req_addr_o,
   output logic [DATA_W-1:0]   req_wdata_o,
   output logic                adel_o,
   output logic                ades_o,
   output logic [31:0]         badvaddr_o,
   output logic                sc_fail_o,
   output logic [3:0]          ld_op_o,
   output logic [2:0]          ld_off_o,
   output logic                stall_req_o
);

   localparam int          BE_W      = DATA_W / 8;
   localparam int          OFF_W     = $clog2(BE_W);
   localparam int          ENT_W     = 2 + BE_W + 32 + DATA_W;
   localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);

   logic [1:0]        k_s;
   logic [2:0]        lane_s;
   logic              ld_s, st_s, mis_s, sc_drop_s;
   logic              accept_s, push_s, pop_s;
   logic [3:0]        be4_s;
   logic [31:0]       wd32_s;
   logic [BE_W-1:0]   be_s;
   logic [DATA_W-1:0] wdata_s;
   logic [31:0]       phys_s, addr_s;
   logic [ENT_W-1:0]  ent_in_s, ent_out_s;
   logic              full_s, empty_s, head_ld_s;

   logic        adel_q, adel_d;
   logic        ades_q, ades_d;
   logic        sc_fail_q, sc_fail_d;
   logic [31:0] badvaddr_q, badvaddr_d;
   logic        load_pending_q, load_pending_d;
   logic [3:0]  ld_op_q, ld_op_d;
   logic [2:0]  ld_off_q, ld_off_d;

   // Op classification, stall request and accept/enqueue qualification
   always_comb begin
      k_s         = ex_addr_i[1:0];
      ld_s        = is_load(ex_op_i);
      st_s        = is_store(ex_op_i);
      mis_s       = misaligned(ex_op_i, k_s);
      sc_drop_s   = (ex_op_i == EXE_SC_OP) & ~llbit_i;
      stall_req_o = full_s | load_pending_q | (ex_valid_i & ld_s & ~empty_s);
      accept_s    = ex_valid_i & ~stall_i & ~flush_i & ~ex_except_i & ~stall_req_o;
      push_s      = accept_s & (ld_s | st_s) & ~mis_s & ~sc_drop_s;
      pop_s       = req_valid_o & req_ready_i;
   end

   // Byte enables and store data within a 32-bit word, before lane placement
   always_comb begin
      case (ex_op_i)
         EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP:            be4_s = 4'b0001 << k_s;
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:            be4_s = 4'b0011 << k_s;
         EXE_LW_OP, EXE_LL_OP, EXE_SW_OP, EXE_SC_OP:  be4_s = 4'b1111;
         EXE_LWL_OP, EXE_SWL_OP:                      be4_s = (4'b0010 << k_s) - 4'b0001;
         EXE_LWR_OP, EXE_SWR_OP:                      be4_s = 4'b1111 << k_s;
         default:                                     be4_s = 4'b0000;
      endcase
      case (ex_op_i)
         EXE_SB_OP:             wd32_s = {24'h000000, ex_wdata_i[7:0]} << {k_s, 3'b000};
         EXE_SH_OP:             wd32_s = {16'h0000, ex_wdata_i[15:0]} << {k_s, 3'b000};
         EXE_SW_OP, EXE_SC_OP:  wd32_s = ex_wdata_i;
         EXE_SWL_OP:            wd32_s = ex_wdata_i >> {(2'd3 - k_s), 3'b000};
         EXE_SWR_OP:            wd32_s = ex_wdata_i << {k_s, 3'b000};
         default:               wd32_s = 32'h0000_0000;
      endcase
   end

   // Lane placement on a 64-bit bus, kseg mapping and bus-width address alignment
   always_comb begin
      if (DATA_W == 64) begin
         lane_s = {ex_addr_i[2], 2'b00};
      end else begin
         lane_s = 3'd0;
      end
      be_s    = BE_W'(be4_s) << lane_s;
      wdata_s = DATA_W'(wd32_s) << {lane_s, 3'b000};
      if ((KSEG_MAP != 0) && (ex_addr_i[31:30] == KSEG01_SEL)) begin
         phys_s = {3'b000, ex_addr_i[KSEG_PHYS_W-1:0]};
      end else begin
         phys_s = ex_addr_i;
      end
      addr_s   = phys_s & ADDR_MASK;
      ent_in_s = {ld_s, st_s, be_s, addr_s, wdata_s};
   end

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s),
      .wdata_i (ent_in_s),
      .pop_i   (pop_s),
      .rdata_o (ent_out_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   assign req_valid_o = ~empty_s;
   assign {head_ld_s, req_we_o, req_be_o, req_addr_o, req_wdata_o} = ent_out_s;

   // Exception pulses, faulting address capture and in-flight load tracking
   always_comb begin
      adel_d    = accept_s & mis_s & ld_s;
      ades_d    = accept_s & mis_s & st_s;
      sc_fail_d = accept_s & sc_drop_s & ~mis_s;
      if (adel_d | ades_d) begin
         badvaddr_d = ex_addr_i;
      end else begin
         badvaddr_d = badvaddr_q;
      end
      if (push_s & ld_s) begin
         load_pending_d = 1'b1;
         ld_op_d        = ex_op_i;
         ld_off_d       = ex_addr_i[2:0];
      end else if (pop_s & head_ld_s) begin
         load_pending_d = 1'b0;
         ld_op_d        = ld_op_q;
         ld_off_d       = ld_off_q;
      end else begin
         load_pending_d = load_pending_q;
         ld_op_d        = ld_op_q;
         ld_off_d       = ld_off_q;
      end
   end

   // Status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         adel_q         <= 1'b0;
         ades_q         <= 1'b0;
         sc_fail_q      <= 1'b0;
         badvaddr_q     <= 32'h0000_0000;
         load_pending_q <= 1'b0;
         ld_op_q        <= EXE_NOP_OP;
         ld_off_q       <= 3'd0;
      end else begin
         adel_q         <= adel_d;
         ades_q         <= ades_d;
         sc_fail_q      <= sc_fail_d;
         badvaddr_q     <= badvaddr_d;
         load_pending_q <= load_pending_d;
         ld_op_q        <= ld_op_d;
         ld_off_q       <= ld_off_d;
      end
   end

   assign adel_o     = adel_q;
   assign ades_o     = ades_q;
   assign sc_fail_o  = sc_fail_q;
   assign badvaddr_o = badvaddr_q;
   assign ld_op_o    = ld_op_q;
   assign ld_off_o   = ld_off_q;

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: stimulus pushes expected bus requests into a
// scoreboard queue, a negedge monitor pops and compares on every handshake.
module tb_mem_req_queue;
   import mem_req_queue_pkg::*;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0, ex_except = 1'b0, llbit = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [3:0]  ex_op = 4'd0;
   logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
   logic        req_ready = 1'b0;
   logic        req_valid, req_we, adel, ades, sc_fail, stall_req;
   logic [3:0]  req_be, ld_op;
   logic [31:0] req_addr, req_wdata, badvaddr;
   logic [2:0]  ld_off;

   logic        w_valid = 1'b0, w_ready = 1'b0;
   logic [3:0]  w_op = 4'd0;
   logic [31:0] w_addr = 32'd0, w_wdata = 32'd0;
   logic        w_req_valid, w_req_we, w_adel, w_ades, w_sc_fail, w_stall_req;
   logic [7:0]  w_req_be;
   logic [31:0] w_req_addr, w_badvaddr;
   logic [63:0] w_req_wdata;
   logic [3:0]  w_ld_op;
   logic [2:0]  w_ld_off;

   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   mem_req_queue #(.DATA_W(32), .DEPTH(4), .KSEG_MAP(1)) dut (
      .clk(clk), .rst(rst), .ex_valid_i(ex_valid), .ex_op_i(ex_op), .ex_addr_i(ex_addr),
      .ex_wdata_i(ex_wdata), .ex_except_i(ex_except), .llbit_i(llbit), .stall_i(stall),
      .flush_i(flush), .req_valid_o(req_valid), .req_ready_i(req_ready), .req_we_o(req_we),
      .req_be_o(req_be), .req_addr_o(req_addr), .req_wdata_o(req_wdata), .adel_o(adel),
      .ades_o(ades), .badvaddr_o(badvaddr), .sc_fail_o(sc_fail), .ld_op_o(ld_op),
      .ld_off_o(ld_off), .stall_req_o(stall_req));

   mem_req_queue #(.DATA_W(64), .DEPTH(4), .KSEG_MAP(1)) dut64 (
      .clk(clk), .rst(rst), .ex_valid_i(w_valid), .ex_op_i(w_op), .ex_addr_i(w_addr),
      .ex_wdata_i(w_wdata), .ex_except_i(1'b0), .llbit_i(1'b0), .stall_i(1'b0),
      .flush_i(1'b0), .req_valid_o(w_req_valid), .req_ready_i(w_ready), .req_we_o(w_req_we),
      .req_be_o(w_req_be), .req_addr_o(w_req_addr), .req_wdata_o(w_req_wdata), .adel_o(w_adel),
      .ades_o(w_ades), .badvaddr_o(w_badvaddr), .sc_fail_o(w_sc_fail), .ld_op_o(w_ld_op),
      .ld_off_o(w_ld_off), .stall_req_o(w_stall_req));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", name, act, want);
      end
   endtask

   // Scoreboard monitor: every bus handshake must match the oldest expected request
   always @(negedge clk) begin
      if (!rst && req_valid && req_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req: got addr=0x%0h be=0x%0h, none expected", req_addr, req_be);
         end else begin
            mon_e = exp_q.pop_front();
            check("req_we", {63'd0, req_we}, {63'd0, mon_e.we});
            check("req_be", {60'd0, req_be}, {60'd0, mon_e.be});
            check("req_addr", {32'd0, req_addr}, {32'd0, mon_e.addr});
            check("req_wdata", {32'd0, req_wdata}, {32'd0, mon_e.wdata});
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.we = we; e.be = be; e.addr = a; e.wdata = d;
      exp_q.push_back(e);
   endtask

   // Present an op and hold it until an edge where the DUT is not stalling it
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d, input logic ll);
      int   n;
      logic blocked;
      n = 0;
      ex_op = op; ex_addr = a; ex_wdata = d; llbit = ll; ex_valid = 1'b1;
      do begin
         @(negedge clk);
         blocked = stall_req;
         @(posedge clk);
         n++;
      end while (blocked && n < 50);
      #1;
      ex_valid = 1'b0;
      if (blocked) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: got stall_req=1 after %0d cycles, want accept", n);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (req_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain", {63'd0, req_valid}, 64'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {63'd0, req_valid}, 64'd0);
      check("rst_stall", {63'd0, stall_req}, 64'd0);
      check("rst_adel", {63'd0, adel}, 64'd0);
      check("rst_badvaddr", {32'd0, badvaddr}, 64'd0);
      check("rst_ld_op", {60'd0, ld_op}, 64'd0);
      rst = 1'b0;

      // 1: kseg-mapped SW
      req_ready = 1'b1;
      push_exp(1'b1, 4'hF, 32'h0000_1004, 32'hAABB_CCDD);
      issue(EXE_SW_OP, 32'h8000_1004, 32'hAABB_CCDD, 1'b0);
      check("sw_valid", {63'd0, req_valid}, 64'd1);
      cyc(1);

      // 2: misaligned SH and LW
      issue(EXE_SH_OP, 32'h0000_0003, 32'h1234_5678, 1'b0);
      check("ades_pulse", {63'd0, ades}, 64'd1);
      check("ades_badvaddr", {32'd0, badvaddr}, 64'h3);
      check("ades_noreq", {63'd0, req_valid}, 64'd0);
      cyc(1);
      check("ades_clear", {63'd0, ades}, 64'd0);
      check("badvaddr_hold", {32'd0, badvaddr}, 64'h3);
      issue(EXE_LW_OP, 32'h0000_0202, 32'h0, 1'b0);
      check("adel_pulse", {63'd0, adel}, 64'd1);
      check("adel_badvaddr", {32'd0, badvaddr}, 64'h202);
      check("adel_nopend", {63'd0, stall_req}, 64'd0);

      // 3: SWL / SWR with k=1
      push_exp(1'b1, 4'b0011, 32'h0000_0100, 32'h0000_1122);
      issue(EXE_SWL_OP, 32'h0000_0101, 32'h1122_3344, 1'b0);
      push_exp(1'b1, 4'b1110, 32'h0000_0100, 32'h2233_4400);
      issue(EXE_SWR_OP, 32'h0000_0101, 32'h1122_3344, 1'b0);
      wait_drain();

      // 4: fill to DEPTH with the bus stalled, then drain in order
      req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push_exp(1'b1, 4'hF, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i));
         issue(EXE_SW_OP, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
      end
      check("full_stall", {63'd0, stall_req}, 64'd1);
      ex_op = EXE_SW_OP; ex_addr = 32'h500; ex_wdata = 32'hDEAD; ex_valid = 1'b1;
      cyc(1);
      ex_valid = 1'b0;
      check("full_hold", {63'd0, stall_req}, 64'd1);
      req_ready = 1'b1;
      wait_drain();
      check("full_release", {63'd0, stall_req}, 64'd0);
      push_exp(1'b1, 4'hF, 32'h0000_0500, 32'h0000_BEEF);
      issue(EXE_SW_OP, 32'h500, 32'hBEEF, 1'b0);
      wait_drain();

      // 5: load waits behind a store, load tracking, SC
      req_ready = 1'b0;
      push_exp(1'b1, 4'hF, 32'h0000_0200, 32'h0000_CAFE);
      issue(EXE_SW_OP, 32'h200, 32'hCAFE, 1'b0);
      ex_op = EXE_LW_OP; ex_addr = 32'h204; ex_wdata = 32'h0; ex_valid = 1'b1;
      #1;
      check("ld_behind_st_stall", {63'd0, stall_req}, 64'd1);
      req_ready = 1'b1;
      push_exp(1'b0, 4'hF, 32'h0000_0204, 32'h0);
      issue(EXE_LW_OP, 32'h204, 32'h0, 1'b0);
      check("ld_op", {60'd0, ld_op}, 64'd5);
      check("ld_off", {61'd0, ld_off}, 64'd4);
      check("ld_pending_stall", {63'd0, stall_req}, 64'd1);
      cyc(1);
      check("ld_done_stall", {63'd0, stall_req}, 64'd0);
      check("ld_op_hold", {60'd0, ld_op}, 64'd5);
      issue(EXE_SC_OP, 32'h300, 32'h55, 1'b0);
      check("sc_fail_pulse", {63'd0, sc_fail}, 64'd1);
      check("sc_fail_noreq", {63'd0, req_valid}, 64'd0);
      cyc(1);
      check("sc_fail_clear", {63'd0, sc_fail}, 64'd0);
      push_exp(1'b1, 4'hF, 32'h0000_0300, 32'h0000_0055);
      issue(EXE_SC_OP, 32'h300, 32'h55, 1'b1);
      wait_drain();

      // 6: flush keeps queued entries; reset discards them
      req_ready = 1'b0;
      push_exp(1'b1, 4'hF, 32'h0000_0600, 32'h0000_0006);
      issue(EXE_SW_OP, 32'h600, 32'h6, 1'b0);
      push_exp(1'b1, 4'hF, 32'h0000_0604, 32'h0000_0007);
      issue(EXE_SW_OP, 32'h604, 32'h7, 1'b0);
      ex_op = EXE_SW_OP; ex_addr = 32'h608; ex_wdata = 32'h8; ex_valid = 1'b1; flush = 1'b1;
      cyc(1);
      ex_valid = 1'b0; flush = 1'b0;
      check("flush_keep", {63'd0, req_valid}, 64'd1);
      req_ready = 1'b1;
      wait_drain();
      req_ready = 1'b0;
      issue(EXE_SW_OP, 32'h700, 32'h9, 1'b0);
      issue(EXE_SW_OP, 32'h704, 32'hA, 1'b0);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("rst_mid_valid", {63'd0, req_valid}, 64'd0);
      check("rst_mid_stall", {63'd0, stall_req}, 64'd0);
      req_ready = 1'b1;
      cyc(3);

      // 7: 64-bit bus lane placement
      w_ready = 1'b1;
      w_op = EXE_SB_OP; w_addr = 32'h6; w_wdata = 32'h5A; w_valid = 1'b1;
      cyc(1);
      w_valid = 1'b0;
      check("w64_sb_valid", {63'd0, w_req_valid}, 64'd1);
      check("w64_sb_be", {56'd0, w_req_be}, 64'h40);
      check("w64_sb_wdata", w_req_wdata, 64'h005A_0000_0000_0000);
      check("w64_sb_addr", {32'd0, w_req_addr}, 64'h0);
      cyc(1);
      w_op = EXE_SW_OP; w_addr = 32'h8000_0004; w_wdata = 32'h1234_5678; w_valid = 1'b1;
      cyc(1);
      w_valid = 1'b0;
      check("w64_sw_be", {56'd0, w_req_be}, 64'hF0);
      check("w64_sw_wdata", w_req_wdata, 64'h1234_5678_0000_0000);
      check("w64_sw_addr", {32'd0, w_req_addr}, 64'h0);
      check("w64_sw_we", {63'd0, w_req_we}, 64'd1);
      cyc(2);

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
